// File: rtl/arm_pkg.sv
// Shared widths, status-flag bit positions and the pipeline entry types
// used by the execute/memory stage register.
package arm_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int STAT_W = 4;

  // Status vector layout {Z,C,N,V}
  localparam int ST_Z = 3;
  localparam int ST_C = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;

  // Memory / writeback control carried with each instruction
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // One pipeline slot as held by the stage register
  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [DEST_W-1:0] dest;
    ctrl_t             ctrl;
  } entry_t;

endpackage

// File: rtl/stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush.
// Main slot M drives the output; skid slot S catches the beat accepted while
// M is stalled. in_ready is registered (~S.valid), so it never depends
// combinationally on out_ready. Ordering is strict FIFO.
module stage_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic m_valid_reg, m_valid_next;
  logic s_valid_reg, s_valid_next;
  logic in_ready_reg, in_ready_next;
  T     m_data_reg, m_data_next;
  T     s_data_reg, s_data_next;

  logic acc;
  logic deq;

  assign acc = in_valid & in_ready_reg & ~flush;
  assign deq = m_valid_reg & out_ready;

  // Slot movement for this edge; flush wins over every handshake
  always_comb begin
    m_valid_next = m_valid_reg;
    s_valid_next = s_valid_reg;
    m_data_next  = m_data_reg;
    s_data_next  = s_data_reg;
    if (flush) begin
      // Only valid bits are cleared; data is left stale
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (!m_valid_reg) begin
      if (acc) begin
        m_valid_next = 1'b1;
        m_data_next  = in_data;
      end
    end else if (deq) begin
      if (s_valid_reg) begin
        // S refills M; no accept is possible because in_ready was low
        m_data_next  = s_data_reg;
        s_valid_next = 1'b0;
      end else if (acc) begin
        m_data_next = in_data;
      end else begin
        m_valid_next = 1'b0;
      end
    end else if (acc) begin
      // M stalled: park the new beat in S and close the input next cycle
      s_valid_next = 1'b1;
      s_data_next  = in_data;
    end
    in_ready_next = ~s_valid_next;
  end

  // Slot registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg  <= 1'b0;
      s_valid_reg  <= 1'b0;
      in_ready_reg <= 1'b1;
      m_data_reg   <= '0;
      s_data_reg   <= '0;
    end else begin
      m_valid_reg  <= m_valid_next;
      s_valid_reg  <= s_valid_next;
      in_ready_reg <= in_ready_next;
      m_data_reg   <= m_data_next;
      s_data_reg   <= s_data_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = m_valid_reg;
  assign out_data  = m_data_reg;

endmodule

// File: rtl/exe_mem_stage.sv
// EXE -> MEM pipeline stage register.
// Holds the ALU result, store data, destination and control in an elastic
// 2-entry skid buffer, owns the {Z,C,N,V} status register and returns C to
// the ALU as carry_in.
// Optional: define EXE_FWD_EN to expose the main entry as an ALU-result
// forwarding source (fwd_valid/fwd_dest/fwd_data); otherwise those are 0.
module exe_mem_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int STAT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [STAT_W-1:0] status_in,
  input  logic              s_update,
  input  logic [DEST_W-1:0] dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] val_rm,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [STAT_W-1:0] status_reg,
  output logic              carry_flag,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
);

  import arm_pkg::*;

  entry_t in_entry;
  entry_t m_entry;
  logic   buf_in_ready;
  logic   acc;

  logic [STAT_W-1:0] stat_reg, stat_next;
  logic [CTRL_W-1:0] m_ctrl_bits;
  logic [CTRL_W-1:0] out_ctrl_bits;

  // Pack the incoming instruction into one pipeline entry
  always_comb begin
    in_entry               = '0;
    in_entry.alu_res       = alu_res;
    in_entry.val_rm        = val_rm;
    in_entry.dest          = dest;
    in_entry.ctrl.wb_en    = wb_en;
    in_entry.ctrl.mem_r_en = mem_r_en;
    in_entry.ctrl.mem_w_en = mem_w_en;
  end

  stage_skid_buf #(
    .T (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (buf_in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (m_entry)
  );

  assign in_ready = buf_in_ready;

  // Same acceptance condition the skid buffer uses; flags follow accepted beats only
  assign acc = in_valid & buf_in_ready & ~flush;

  // Route each ALU flag into its status slot when an S-flagged beat is accepted
  always_comb begin
    stat_next = stat_reg;
    if (acc && s_update) begin
      stat_next[ST_Z] = status_in[ST_Z];
      stat_next[ST_C] = status_in[ST_C];
      stat_next[ST_N] = status_in[ST_N];
      stat_next[ST_V] = status_in[ST_V];
    end
  end

  // Architectural status register
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reg <= '0;
    end else begin
      stat_reg <= stat_next;
    end
  end

  assign status_reg = stat_reg;
  assign carry_flag = stat_reg[ST_C];

  // Main-entry data goes out as held; control is masked by out_valid so MEM
  // never acts on a stale slot
  assign out_alu_res = m_entry.alu_res;
  assign out_val_rm  = m_entry.val_rm;
  assign out_dest    = m_entry.dest;
  assign m_ctrl_bits = m_entry.ctrl;

  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign out_ctrl_bits[gi] = m_ctrl_bits[gi] & out_valid;
    end
  endgenerate

  assign out_wb_en    = out_ctrl_bits[2];
  assign out_mem_r_en = out_ctrl_bits[1];
  assign out_mem_w_en = out_ctrl_bits[0];

`ifdef EXE_FWD_EN
  // Loads are excluded: their value only exists after the memory access
  assign fwd_valid = out_valid & m_entry.ctrl.wb_en & ~m_entry.ctrl.mem_r_en;
  assign fwd_dest  = m_entry.dest;
  assign fwd_data  = m_entry.alu_res;
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed and randomized checks of exe_mem_stage against a queue-based
// model of a 2-deep elastic FIFO plus a flag register.
module tb_exe_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_res;
  logic [3:0]  status_in;
  logic        s_update;
  logic [3:0]  dest;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] val_rm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_res;
  logic [31:0] out_val_rm;
  logic [3:0]  out_dest;
  logic        out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [3:0]  status_reg;
  logic        carry_flag;
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_data;

  exe_mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_res      (alu_res),
    .status_in    (status_in),
    .s_update     (s_update),
    .dest         (dest),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .val_rm       (val_rm),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_res  (out_alu_res),
    .out_val_rm   (out_val_rm),
    .out_dest     (out_dest),
    .out_wb_en    (out_wb_en),
    .out_mem_r_en (out_mem_r_en),
    .out_mem_w_en (out_mem_w_en),
    .status_reg   (status_reg),
    .carry_flag   (carry_flag),
    .fwd_valid    (fwd_valid),
    .fwd_dest     (fwd_dest),
    .fwd_data     (fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] rm;
    logic [3:0]  d;
    logic        wb;
    logic        mr;
    logic        mw;
  } ent_t;

  ent_t       q[$];
  logic [3:0] st_m;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare every DUT output against the model
  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("status_reg", 32'(status_reg), 32'(st_m));
    chk("carry_flag", 32'(carry_flag), 32'(st_m[2]));
    if (q.size() > 0) begin
      chk("out_alu_res", out_alu_res, q[0].a);
      chk("out_val_rm", out_val_rm, q[0].rm);
      chk("out_dest", 32'(out_dest), 32'(q[0].d));
      chk("out_wb_en", 32'(out_wb_en), 32'(q[0].wb));
      chk("out_mem_r_en", 32'(out_mem_r_en), 32'(q[0].mr));
      chk("out_mem_w_en", 32'(out_mem_w_en), 32'(q[0].mw));
    end else begin
      chk("out_ctrl_idle", 32'({out_wb_en, out_mem_r_en, out_mem_w_en}), 32'(0));
    end
`ifdef EXE_FWD_EN
    if (q.size() > 0 && q[0].wb && !q[0].mr) begin
      chk("fwd_valid", 32'(fwd_valid), 32'(1));
      chk("fwd_dest", 32'(fwd_dest), 32'(q[0].d));
      chk("fwd_data", fwd_data, q[0].a);
    end else begin
      chk("fwd_valid", 32'(fwd_valid), 32'(0));
    end
`else
    chk("fwd_off", 32'({fwd_valid, fwd_dest}) | fwd_data, 32'(0));
`endif
  endtask

  // Advance the model with the current inputs, clock the DUT, then compare
  task automatic tick();
    bit   acc, deq;
    ent_t e;
    acc  = in_valid && (q.size() < 2) && !flush;
    deq  = (q.size() > 0) && out_ready;
    e.a  = alu_res;
    e.rm = val_rm;
    e.d  = dest;
    e.wb = wb_en;
    e.mr = mem_r_en;
    e.mw = mem_w_en;
    if (rst) begin
      q.delete();
      st_m = 4'b0000;
    end else if (flush) begin
      q.delete();
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (s_update) st_m = status_in;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic beat(input logic v, input logic [31:0] a);
    in_valid = v;
    alu_res  = a;
    val_rm   = ~a;
    dest     = a[3:0];
    wb_en    = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = a[0];
    s_update = 1'b0;
    status_in = 4'b0000;
  endtask

  initial begin
    st_m = 4'b0000;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    beat(1'b1, 32'h55);

    // Reset held with in_valid asserted
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_status", 32'(status_reg), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_data", out_alu_res | out_val_rm | 32'(out_dest), 32'(0));

    // First beat after release appears next cycle
    rst = 1'b0;
    out_ready = 1'b1;
    beat(1'b1, 32'hA);
    tick();
    chk("first_valid", 32'(out_valid), 32'(1));
    chk("first_data", out_alu_res, 32'hA);

    // Streaming at full rate
    for (int k = 1; k <= 4; k++) begin
      beat(1'b1, 32'(k));
      tick();
      chk("stream_data", out_alu_res, 32'(k));
      chk("stream_ready", 32'(in_ready), 32'(1));
    end
    beat(1'b0, 32'h0);
    tick();

    // Back-pressure into the skid slot
    out_ready = 1'b0;
    beat(1'b1, 32'd5);
    tick();
    beat(1'b1, 32'd6);
    tick();
    chk("bp_ready_low", 32'(in_ready), 32'(0));
    chk("bp_hold5", out_alu_res, 32'd5);
    beat(1'b0, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_then6", out_alu_res, 32'd6);
    chk("bp_ready_back", 32'(in_ready), 32'(1));
    tick();
    chk("bp_drained", 32'(out_valid), 32'(0));

    // Flag updates
    beat(1'b1, 32'h7);
    s_update = 1'b1;
    status_in = 4'b0100;
    tick();
    chk("flag_set", 32'(status_reg), 32'h4);
    chk("flag_carry", 32'(carry_flag), 32'(1));
    beat(1'b1, 32'h8);
    status_in = 4'b1000;
    tick();
    chk("flag_noupd", 32'(status_reg), 32'h4);
    beat(1'b0, 32'h0);
    tick();

    // Flush with both slots full and an S-flagged input present
    out_ready = 1'b0;
    beat(1'b1, 32'h21);
    tick();
    beat(1'b1, 32'h22);
    tick();
    chk("flush_full", 32'(in_ready), 32'(0));
    flush = 1'b1;
    beat(1'b1, 32'h23);
    s_update = 1'b1;
    status_in = 4'b1111;
    tick();
    chk("flush_valid", 32'(out_valid), 32'(0));
    chk("flush_status", 32'(status_reg), 32'h4);
    chk("flush_ready", 32'(in_ready), 32'(1));
    flush = 1'b0;

    // Forwarding source
    beat(1'b1, 32'h10);
    dest = 4'd7;
    tick();
`ifdef EXE_FWD_EN
    chk("fwd_alu_valid", 32'(fwd_valid), 32'(1));
    chk("fwd_alu_dest", 32'(fwd_dest), 32'd7);
    chk("fwd_alu_data", fwd_data, 32'h10);
`else
    chk("fwd_tied_valid", 32'(fwd_valid), 32'(0));
    chk("fwd_tied_bus", fwd_data | 32'(fwd_dest), 32'(0));
`endif
    out_ready = 1'b1;
    beat(1'b1, 32'h10);
    dest = 4'd7;
    mem_r_en = 1'b1;
    tick();
    chk("fwd_load_valid", 32'(fwd_valid), 32'(0));
    beat(1'b0, 32'h0);
    tick();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_res   = $urandom;
      val_rm    = $urandom;
      dest      = 4'($urandom);
      wb_en     = 1'($urandom);
      mem_r_en  = 1'($urandom);
      mem_w_en  = 1'($urandom);
      s_update  = 1'($urandom);
      status_in = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Pipeline stage register between the execute-stage ALU and the memory stage.
- Captures the ALU result, destination and memory/writeback control on a valid/ready handshake, using a 2-entry skid buffer for elastic back-pressure.
- Owns the architectural status register {Z,C,N,V}, updated when S-flagged instructions are accepted. Returns the C flag to the ALU as carry_in.

Parameters:
- DATA_W, 32, width of the ALU result and store data
- DEST_W, 4, register-file destination index width
- STAT_W, 4, status vector width; bit order is {Z,C,N,V}

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EXE holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- alu_res  in  DATA_W  ALU result (address for LDR/STR)
- status_in  in  STAT_W  ALU flags {Z,C,N,V}
- s_update  in  1  instruction sets flags
- dest  in  DEST_W  destination register
- wb_en, mem_r_en, mem_w_en  in  1 each  control bits
- val_rm  in  DATA_W  store data
- flush  in  1  squash all held and incoming entries (branch taken)
- out_valid  out  1  main entry valid
- out_ready  in  1  MEM accepts this cycle
- out_alu_res, out_val_rm  out  DATA_W  main-entry data
- out_dest  out  DEST_W  main-entry destination
- out_wb_en, out_mem_r_en, out_mem_w_en  out  1  main-entry control
- status_reg  out  STAT_W  current flags
- carry_flag  out  1  status_reg C bit, to ALU carry_in
- fwd_valid  out  1  see Optional Feature
- fwd_dest  out  DEST_W  see Optional Feature
- fwd_data  out  DATA_W  see Optional Feature

Behaviour:
- Storage: main entry M (drives out_*) and skid entry S. Each entry has its own valid bit.
- Reset: M.valid=0, S.valid=0, status_reg=0, in_ready=1, out_valid=0. All out_* data and control are 0. Reset overrides flush and any handshake.
- Handshake events:
  - acc = in_valid & in_ready & ~flush
  - deq = out_valid & out_ready
- in_ready is registered: in_ready = ~S.valid after the edge. Never combinationally dependent on out_ready.
- Next-state rules, given M.valid and S.valid before the edge:
  - M empty, acc: M <= input.
  - M full, deq, S empty, acc: M <= input.
  - M full, deq, S empty, no acc: M.valid <= 0.
  - M full, deq, S full: M <= S, S.valid <= 0. acc is impossible because in_ready=0.
  - M full, no deq, acc: S <= input, so in_ready goes to 0 next cycle.
  - Anything else: hold.
- Latency: input accepted at edge k appears on out_* at cycle k+1 when M was empty or dequeued at edge k.
- Throughput: 1 per cycle while out_ready=1.
- Ordering is strict FIFO; S never bypasses M.
- Flush: at the edge, M.valid<=0 and S.valid<=0. The concurrent input is dropped and status is not updated. A concurrent deq still completes downstream. Data fields may hold stale values; only valid bits are cleared.
- Status register: on acc & s_update, status_reg <= status_in at the same edge. The next EXE instruction therefore sees the updated carry_flag. No update when s_update=0, on flush, or when in_ready=0.
- out_wb_en, out_mem_r_en and out_mem_w_en are gated by out_valid; they are 0 whenever out_valid=0.

Optional Feature:
- Macro EXE_FWD_EN.
- When defined: fwd_valid = M.valid & M.wb_en & ~M.mem_r_en, fwd_dest = M.dest, fwd_data = M.alu_res. This gives the hazard unit an ALU-result forwarding source.
- When undefined: fwd_valid, fwd_dest and fwd_data are tied to 0, and no logic is generated for them.

Decomposition:
- Package arm_pkg holds:
  - DATA_W, DEST_W and STAT_W constants
  - status bit indices: Z=3, C=2, N=1, V=0
  - a packed ctrl typedef {wb_en, mem_r_en, mem_w_en}
  - an entry typedef {alu_res, val_rm, dest, ctrl}
- One sub-module, stage_skid_buf: a generic 2-entry valid/ready skid buffer over the entry type, with flush.
- exe_mem_stage instantiates stage_skid_buf and adds the status register and forwarding logic.

Test Plan:
- Reset mid-stream: hold rst with in_valid=1 for 2 cycles, then release -> out_valid=0, status_reg=0, in_ready=1. The first accepted beat appears on the next cycle.
- Streaming: 4 beats alu_res=1,2,3,4, out_ready=1 -> outputs 1,2,3,4 on consecutive cycles, in_ready held at 1.
- Back-pressure:
  - Accept 5, drop out_ready, accept 6 -> in_ready=0 next cycle, out_alu_res=5.
  - Raise out_ready -> outputs 5 then 6 in order, in_ready returns to 1.
- Flags:
  - Accept status_in=4'b0100 with s_update=1 -> status_reg=4'b0100 and carry_flag=1 next cycle.
  - Next beat with s_update=0 and status_in=4'b1000 -> status_reg unchanged.
- Flush:
  - M and S full, assert flush with in_valid=1, s_update=1, status_in=4'b1111 -> out_valid=0 next cycle, status_reg unchanged, in_ready=1.
- EXE_FWD_EN:
  - Defined: M holds dest=7, wb_en=1, mem_r_en=0, alu_res=0x10 -> fwd_valid=1, fwd_dest=7, fwd_data=0x10.
  - Defined, with mem_r_en=1 -> fwd_valid=0.
  - Undefined -> all fwd_* outputs are 0.
